// File: rtl/fpu_regfile_sb.sv
// FPU register file with integrated busy-bit scoreboard for RAW/WAW hazard detection.
// Optional macro FPU_RF_BYPASS_EN adds write-first bypass of writeback data/busy onto every read port.
module fpu_regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 3,
  localparam int AW   = $clog2(NREGS),
  localparam int CW   = $clog2(NREGS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_rd,
  output logic                  issue_ready,
  input  logic                  wb_valid,
  input  logic [AW-1:0]         wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  output logic [CW-1:0]         busy_count
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [CW-1:0]    count_q, count_d;
  logic             issue_fire;

  // Issue handshake: the op is accepted on a cycle where issue_valid && issue_ready.
  // issue_ready looks only at registered busy state, so a same-cycle writeback never raises it.
  assign issue_ready = !busy_q[issue_rd];
  assign issue_fire  = issue_valid && issue_ready;
  assign busy_count  = count_q;

  // Issue is applied after writeback so a same-register collision leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid)   busy_d[wb_rd]    = 1'b0;
    if (issue_fire) busy_d[issue_rd] = 1'b1;
  end

  // A firing issue always targets a clear bit and a same-register writeback never
  // clears a set one, so +1 and -1 are independent.
  always_comb begin
    count_d = count_q;
    if (issue_fire)                 count_d = count_d + CW'(1);
    if (wb_valid && busy_q[wb_rd])  count_d = count_d - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
      if (wb_valid) regs_q[wb_rd] <= wb_data;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = rd_addr[k*AW +: AW];
`ifdef FPU_RF_BYPASS_EN
    logic hit;
    assign hit = wb_valid && (wb_rd == addr);
    assign rd_data[k*XLEN +: XLEN] = hit ? wb_data : regs_q[addr];
    assign rd_busy[k] = hit ? (issue_fire && (issue_rd == addr)) : busy_q[addr];
`else
    assign rd_data[k*XLEN +: XLEN] = regs_q[addr];
    assign rd_busy[k] = busy_q[addr];
`endif
  end

endmodule
